// File: rtl/pc_module.sv
// Program counter register with sequential/target next-PC select and a combinational pc+step output.
// Optional macro PC_ALIGN_EN clears bits [1:0] of a selected alu target before it is loaded.
module pc_module #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] alu,
    input  logic        PCSel,
    output logic [31:0] pc,
    output logic [31:0] pc_4
);

    logic [31:0] pc_q;
    logic [31:0] pc_seq;
    logic [31:0] target;
    logic [31:0] next_pc;

    // Wraps modulo 2^32 by width truncation; no carry is kept.
    assign pc_seq = pc_q + PC_STEP;

`ifdef PC_ALIGN_EN
    assign target = {alu[31:2], 2'b00};
`else
    assign target = alu;
`endif

    always_comb begin
        next_pc = pc_seq;
        if (PCSel == 1'b1) begin
            next_pc = target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= next_pc;
        end
    end

    assign pc   = pc_q;
    assign pc_4 = pc_seq;

endmodule

// File: tb/tb_pc_module.sv
// Directed bench for pc_module: per-cycle reference-model comparison plus literal checkpoints.
`timescale 1ps/1ps
module tb_pc_module;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu;
    logic        PCSel;
    logic [31:0] pc;
    logic [31:0] pc_4;

    int tests;
    int fails;
    logic [31:0] m_pc;
    bit          done;

    pc_module #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .alu   (alu),
        .PCSel (PCSel),
        .pc    (pc),
        .pc_4  (pc_4)
    );

    initial clk = 1'b0;
    always #400 clk = ~clk;

    function automatic logic [31:0] aligned_target(input logic [31:0] a);
`ifdef PC_ALIGN_EN
        return a & 32'hFFFF_FFFC;
`else
        return a;
`endif
    endfunction

    // Reference: what the PC register must hold after each edge, from the select rule.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            m_pc = RESET_PC;
        else if (PCSel === 1'b1)
            m_pc = aligned_target(alu);
        else
            m_pc = m_pc + PC_STEP;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!done) begin
            check("model_pc", pc, m_pc);
            check("model_pc_4", pc_4, m_pc + PC_STEP);
        end
    end

    task automatic at(input longint t);
        if (t > $time) #(t - $time);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        done  = 1'b0;
        rst_n = 1'b0;
        PCSel = 1'b0;
        alu   = 32'h0;

        at(100);
        check("reset_pc", pc, 32'h0);
        check("reset_pc_4", pc_4, 32'h4);
        at(200);   rst_n = 1'b1;
        at(401);   check("seq_1", pc, 32'h4);
        at(1201);  check("seq_2", pc, 32'h8);
                   check("seq_2_pc_4", pc_4, 32'hC);
        at(1600);  PCSel = 1'b1; alu = 32'h44;
        at(2001);  check("jump", pc, 32'h44);
        at(2801);  check("jump_hold", pc, 32'h44);
                   check("jump_hold_pc_4", pc_4, 32'h48);
        at(3200);  PCSel = 1'b0;
        at(3601);  check("resume_1", pc, 32'h48);
        at(4401);  check("resume_2", pc, 32'h4C);
        at(5201);  check("resume_3", pc, 32'h50);
        at(6001);  check("resume_4", pc, 32'h54);
        at(6400);  PCSel = 1'b1; alu = 32'h44;
        at(6801);  check("rejump", pc, 32'h44);
        at(7200);  alu = 32'hFFFF_FFFC;
        at(7601);  check("top_pc", pc, 32'hFFFF_FFFC);
                   check("top_pc_4", pc_4, 32'h0);
        at(8000);  PCSel = 1'b0;
        at(8401);  check("wrap_pc", pc, 32'h0);
                   check("wrap_pc_4", pc_4, 32'h4);
        at(8800);  PCSel = 1'b1; alu = 32'h47;
`ifdef PC_ALIGN_EN
        at(9201);  check("align", pc, 32'h44);
`else
        at(9201);  check("verbatim", pc, 32'h47);
`endif
        at(9600);  PCSel = 1'b0; alu = 'x;
`ifdef PC_ALIGN_EN
        at(10001); check("x_ignored", pc, 32'h48);
`else
        at(10001); check("x_ignored", pc, 32'h4B);
`endif
        tests++;
        if ($isunknown(pc)) begin
            fails++;
            $display("FAIL pc_known: got %h expected no unknown bits", pc);
        end
        at(10400); PCSel = 1'b1; alu = 32'h100;
        at(10500); rst_n = 1'b0;
        at(10501); check("midreset_pc", pc, 32'h0);
                   check("midreset_pc_4", pc_4, 32'h4);
        at(10801); check("midreset_hold_1", pc, 32'h0);
        at(11601); check("midreset_hold_2", pc, 32'h0);
        at(12000); rst_n = 1'b1;
        at(12401); check("post_reset_first", pc, 32'h100);
        at(12700);
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_module.md
PC_MODULE -- requirements
Module: pc_module

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, value loaded into pc on reset.
REQ-002 Parameter PC_STEP, default 32'd4, sequential increment added to pc.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 alu  input  32  branch/jump target from ALU.
REQ-006 PCSel  input  1  next-PC select: 0 = sequential, 1 = alu target.
REQ-007 pc  output  32  current program counter, registered.
REQ-008 pc_4  output  32  pc + PC_STEP, combinational, for the link/writeback path.

Function
REQ-009 The block SHALL hold one 32-bit register driving pc directly.
REQ-010 At each rising clk with rst_n high, the block SHALL load next_pc: alu when PCSel=1, pc+PC_STEP when PCSel=0.
REQ-011 Latency SHALL be one cycle: a PCSel/alu value sampled at edge N appears on pc after edge N.
REQ-012 pc_4 SHALL equal pc+PC_STEP, combinational from the register, never from alu.
REQ-013 Addition SHALL be unsigned modulo 2^32: pc=32'hFFFF_FFFC gives pc_4=32'h0000_0000, with no flag or saturation.
REQ-014 When PCSel=0, alu SHALL be ignored, including X/Z values; pc SHALL NOT go unknown.
REQ-015 PCSel held at 1 over consecutive edges SHALL reload the same alu value each edge, so pc stays constant.
REQ-016 No enable or stall input exists; pc SHALL update on every rising edge outside reset.

Reset
REQ-017 rst_n low SHALL force pc=RESET_PC immediately, independent of clk.
REQ-018 During reset, pc_4 SHALL read RESET_PC+PC_STEP.
REQ-019 Reset asserted mid-operation SHALL override any pending PCSel/alu value.
REQ-020 The first rising edge after rst_n rises SHALL perform a normal update from RESET_PC.

Configuration
REQ-021 Macro PC_ALIGN_EN defined: a selected alu target SHALL have bits [1:0] forced to 0 before loading.
REQ-022 PC_ALIGN_EN undefined: the alu target SHALL be loaded verbatim.
REQ-023 Under either setting, the sequential path and the port list SHALL be identical.

Verification
REQ-024 Reset: rst_n=0 at any time -> pc=0x0, pc_4=0x4 immediately, with no clock edge needed.
REQ-025 Sequential: clk period 800 ps, rst_n released at 200 ps, PCSel=0 -> pc=0x4 after the edge at 400 ps, pc=0x8 after 1200 ps, with pc_4 tracking pc+4.
REQ-026 Jump: at 1600 ps set PCSel=1, alu=0x44 -> pc=0x44 after 2000 ps; pc stays 0x44 after 2800 ps; pc_4=0x48.
REQ-027 Resume: PCSel=0 at 3200 ps -> pc reads 0x48, 0x4C, 0x50, 0x54 after the edges at 3600, 4400, 5200, 6000 ps; PCSel=1 at 6400 ps with alu=0x44 -> pc=0x44 after 6800 ps.
REQ-028 Wrap and alignment: pc=0xFFFF_FFFC, PCSel=0 -> pc=0x0, pc_4=0x4; alu=0x47, PCSel=1 -> pc=0x44 with PC_ALIGN_EN, pc=0x47 without.
REQ-029 Mid-run reset: drive rst_n low between edges while PCSel=1, alu=0x100 -> pc=0x0 at once and stays 0x0 until rst_n rises.
